ntt_resp_tracker: RTL and testbench
===================================

NTT_RESP_TRACKER -- requirements
Module: ntt_resp_tracker

Interface
REQ-001 SHALL have parameter RD_LAT, default 2, memory read latency in cycles (1..8).
REQ-002 SHALL have parameter BU_LAT, default 10, butterfly pipeline latency in cycles (1..32).
REQ-003 SHALL have parameter WR_LAT, default 1, memory write-commit latency in cycles (1..8).
REQ-004 SHALL have parameter ITE_LEN, default 64, AGU address grants per iteration (2..255).
REQ-005 SHALL have parameter MAX_PEND, default 16, results-awaiting-write capacity (1..255).
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have ports AGU_enable, r_enable, ntt_enable, w_enable  input  1 each  controller requests.
REQ-009 SHALL have port flush  input  1  synchronous abort.
REQ-010 SHALL have ports BN_MA_out_en, r_enable_out, ntt_done, w_enable_out, AGU_done, ite_done  output  1 each  responses.
REQ-011 SHALL have port pend_cnt  output  8  results produced but not yet written.
REQ-012 SHALL have ports err_ovf, err_unf  output  1 each  sticky error flags.

Function
REQ-013 SHALL implement FSM IDLE, RUN, DRAIN, DONE; state after reset is IDLE.
REQ-014 IDLE->RUN on AGU_enable=1; that grant SHALL be counted as grant 1.
REQ-015 In RUN, each cycle with AGU_enable=1 SHALL increment grant counter agu_cnt; BN_MA_out_en SHALL equal AGU_enable registered one cycle (only grants accepted in IDLE/RUN).
REQ-016 When the ITE_LEN-th grant is accepted, AGU_done SHALL pulse high the next cycle, agu_cnt SHALL clear, FSM SHALL go RUN->DRAIN.
REQ-017 AGU_enable in DRAIN or DONE SHALL be ignored (no BN_MA_out_en, no count).
REQ-018 r_enable_out SHALL equal r_enable delayed exactly RD_LAT cycles, in every state.
REQ-019 ntt_done SHALL equal ntt_enable delayed exactly BU_LAT cycles; back-to-back inputs SHALL give back-to-back outputs.
REQ-020 w_enable_out SHALL equal w_enable delayed exactly WR_LAT cycles.
REQ-021 pend_cnt SHALL increment on ntt_done, decrement on w_enable, hold when both or neither occur.
REQ-022 ntt_done with pend_cnt=MAX_PEND and no w_enable SHALL set err_ovf and saturate pend_cnt.
REQ-023 w_enable with pend_cnt=0 and no ntt_done SHALL set err_unf and hold pend_cnt at 0.
REQ-024 DRAIN->DONE when all three delay lines are empty, pend_cnt=0, and r_enable/ntt_enable/w_enable are all 0 in that cycle.
REQ-025 In DONE, ite_done SHALL be high for exactly one cycle; FSM SHALL return to IDLE next cycle.
REQ-026 flush=1 SHALL, at the next edge, clear delay lines, agu_cnt, pend_cnt, all pulse outputs, and force IDLE; err_ovf/err_unf SHALL be preserved; flush overrides all same-cycle inputs.
REQ-027 Simultaneous events in one cycle (grant, read, compute, write) SHALL all be processed independently.

Reset
REQ-028 rst=0 SHALL immediately force IDLE and all outputs, counters, delay lines, error flags to 0, regardless of clock.
REQ-029 Reset mid-iteration SHALL discard all in-flight responses; no response pulse SHALL appear after release without a new request.
REQ-030 Only rst SHALL clear err_ovf/err_unf.

Verification
REQ-031 Single r_enable pulse at cycle 5, RD_LAT=2 -> r_enable_out high at cycle 7 only.
REQ-032 64 consecutive AGU_enable cycles from IDLE -> 64 BN_MA_out_en cycles, AGU_done one pulse the cycle after grant 64, FSM in DRAIN.
REQ-033 8 ntt_enable back-to-back, BU_LAT=10 -> 8 contiguous ntt_done; pend_cnt reaches 8; 8 w_enable -> pend_cnt 0, ite_done one pulse once lines empty.
REQ-034 MAX_PEND=4, 5 ntt_done without writes -> pend_cnt=4, err_ovf=1; w_enable at pend_cnt 0 -> err_unf=1.
REQ-035 flush during RUN with 3 results in BU pipeline -> no ntt_done afterward, IDLE, pend_cnt=0, errors retained.
REQ-036 rst=0 asserted mid-DRAIN -> all outputs 0 immediately, no pulses after release.

Source files
------------

// File: rtl/ntt_resp_tracker.sv
// ntt_resp_tracker
//   Tracks the progress of one NTT iteration for the controller. It counts
//   AGU address grants, echoes every read/compute/write request back after
//   the fixed latency of the unit that serves it, keeps a running count of
//   butterfly results waiting to be written back, and reports the end of the
//   iteration once every unit has gone quiet.
//
// Parameters
//   RD_LAT   memory read latency in cycles          (1..8)
//   BU_LAT   butterfly pipeline latency in cycles   (1..32)
//   WR_LAT   memory write-commit latency in cycles  (1..8)
//   ITE_LEN  AGU address grants per iteration       (2..255)
//   MAX_PEND capacity of results awaiting write     (1..255)
//
// Ports
//   clk            sole clock, rising edge
//   rst            asynchronous active-low reset
//   AGU_enable     address grant request (accepted in IDLE/RUN only)
//   r_enable       memory read request
//   ntt_enable     butterfly compute request
//   w_enable       memory write request (retires one pending result)
//   flush          synchronous abort of the current iteration
//   BN_MA_out_en   accepted grant, one cycle later
//   r_enable_out   r_enable delayed RD_LAT cycles
//   ntt_done       ntt_enable delayed BU_LAT cycles
//   w_enable_out   w_enable delayed WR_LAT cycles
//   AGU_done       one-cycle pulse after the ITE_LEN-th grant
//   ite_done       one-cycle pulse when the iteration has fully drained
//   pend_cnt       results produced but not yet written
//   err_ovf        sticky: result arrived with pend_cnt already at MAX_PEND
//   err_unf        sticky: write arrived with no pending result
module ntt_resp_tracker #(
  parameter int RD_LAT   = 2,
  parameter int BU_LAT   = 10,
  parameter int WR_LAT   = 1,
  parameter int ITE_LEN  = 64,
  parameter int MAX_PEND = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       AGU_enable,
  input  logic       r_enable,
  input  logic       ntt_enable,
  input  logic       w_enable,
  input  logic       flush,
  output logic       BN_MA_out_en,
  output logic       r_enable_out,
  output logic       ntt_done,
  output logic       w_enable_out,
  output logic       AGU_done,
  output logic       ite_done,
  output logic [7:0] pend_cnt,
  output logic       err_ovf,
  output logic       err_unf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] LAST_GRANT = 8'(ITE_LEN - 1);
  localparam logic [7:0] PEND_MAX   = 8'(MAX_PEND);

  state_t            state, state_nxt;
  logic [7:0]        agu_cnt, agu_cnt_nxt;
  logic              bn_nxt, agu_done_nxt;

  // One bit per cycle of latency; the oldest bit is the response output.
  logic [RD_LAT-1:0] rd_line;
  logic [BU_LAT-1:0] bu_line;
  logic [WR_LAT-1:0] wr_line;

  logic              lines_empty;
  logic              inputs_idle;
  logic [7:0]        pend_nxt;
  logic              ovf_set, unf_set;

  assign r_enable_out = rd_line[RD_LAT-1];
  assign ntt_done     = bu_line[BU_LAT-1];
  assign w_enable_out = wr_line[WR_LAT-1];

  assign lines_empty  = ~|rd_line & ~|bu_line & ~|wr_line;
  assign inputs_idle  = ~r_enable & ~ntt_enable & ~w_enable;

  // DONE lasts exactly one cycle, so the pulse is a plain state decode.
  assign ite_done     = (state == DONE);

  // ---------------------------------------------------------------------
  // Iteration FSM: next state, grant counter and grant-side pulses.
  // ---------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    state_nxt    = state;
    agu_cnt_nxt  = agu_cnt;
    bn_nxt       = 1'b0;
    agu_done_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (AGU_enable) begin
          bn_nxt      = 1'b1;
          agu_cnt_nxt = 8'd1;
          state_nxt   = RUN;
        end
      end
      RUN: begin
        if (AGU_enable) begin
          bn_nxt = 1'b1;
          if (agu_cnt == LAST_GRANT) begin
            agu_cnt_nxt  = 8'd0;
            agu_done_nxt = 1'b1;
            state_nxt    = DRAIN;
          end else begin
            agu_cnt_nxt = agu_cnt + 8'd1;
          end
        end
      end
      DRAIN: begin
        // Nothing in flight, nothing waiting to be written, and no new
        // request arriving this cycle that would restart activity.
        if (lines_empty && (pend_cnt == 8'd0) && inputs_idle) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Abort wins over whatever the FSM would otherwise do this cycle.
    if (flush) begin
      state_nxt    = IDLE;
      agu_cnt_nxt  = 8'd0;
      bn_nxt       = 1'b0;
      agu_done_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      agu_cnt      <= 8'd0;
      BN_MA_out_en <= 1'b0;
      AGU_done     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state        <= state_nxt;
      agu_cnt      <= agu_cnt_nxt;
      BN_MA_out_en <= bn_nxt;
      AGU_done     <= agu_done_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Response delay lines. Requests are echoed in every FSM state.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the delay lines are a few flops rather than a RAM, so they
      // are reset; that is what discards in-flight responses on reset.
      rd_line <= '0;
      bu_line <= '0;
      wr_line <= '0;
    end else if (flush) begin
      rd_line <= '0;
      bu_line <= '0;
      wr_line <= '0;
    end else begin
      rd_line <= (rd_line << 1) | RD_LAT'(r_enable);
      bu_line <= (bu_line << 1) | BU_LAT'(ntt_enable);
      wr_line <= (wr_line << 1) | WR_LAT'(w_enable);
    end
  end

  // ---------------------------------------------------------------------
  // Pending-result counter. A result and a write in the same cycle cancel.
  // ---------------------------------------------------------------------
  always_comb begin
    pend_nxt = pend_cnt;
    ovf_set  = 1'b0;
    unf_set  = 1'b0;
    if (ntt_done && !w_enable) begin
      if (pend_cnt == PEND_MAX) ovf_set  = 1'b1;
      else                      pend_nxt = pend_cnt + 8'd1;
    end else if (w_enable && !ntt_done) begin
      if (pend_cnt == 8'd0) unf_set  = 1'b1;
      else                  pend_nxt = pend_cnt - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_cnt <= 8'd0;
      err_ovf  <= 1'b0;
      err_unf  <= 1'b0;
    end else if (flush) begin
      // Errors survive an abort so software can still see what went wrong.
      pend_cnt <= 8'd0;
    end else begin
      pend_cnt <= pend_nxt;
      err_ovf  <= err_ovf | ovf_set;
      err_unf  <= err_unf | unf_set;
    end
  end

endmodule

// File: tb/tb_ntt_resp_tracker.sv
// tb_ntt_resp_tracker
//   Self-checking bench for ntt_resp_tracker. A default-parameter instance
//   is the main target; a second instance with MAX_PEND=4 shares the same
//   stimulus and is only inspected in the overflow sequence.
//   Cycle convention: inputs for cycle c are driven and outputs of cycle c
//   are sampled 1 time unit after the rising edge that starts cycle c.
module tb_ntt_resp_tracker;

  localparam int RD_LAT   = 2;
  localparam int BU_LAT   = 10;
  localparam int WR_LAT   = 1;
  localparam int ITE_LEN  = 64;
  localparam int MAX_PEND = 16;
  localparam int N_RAND   = 3000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       agu = 1'b0, r_en = 1'b0, n_en = 1'b0, w_en = 1'b0, flush = 1'b0;

  logic       bn, r_out, n_done, w_out, agu_done, ite_done, ovf, unf;
  logic [7:0] pend;
  logic       s_bn, s_r_out, s_n_done, s_w_out, s_agu_done, s_ite_done, s_ovf, s_unf;
  logic [7:0] s_pend;

  ntt_resp_tracker #(
    .RD_LAT(RD_LAT), .BU_LAT(BU_LAT), .WR_LAT(WR_LAT),
    .ITE_LEN(ITE_LEN), .MAX_PEND(MAX_PEND)
  ) dut (
    .clk(clk), .rst(rst),
    .AGU_enable(agu), .r_enable(r_en), .ntt_enable(n_en), .w_enable(w_en), .flush(flush),
    .BN_MA_out_en(bn), .r_enable_out(r_out), .ntt_done(n_done), .w_enable_out(w_out),
    .AGU_done(agu_done), .ite_done(ite_done), .pend_cnt(pend), .err_ovf(ovf), .err_unf(unf)
  );

  ntt_resp_tracker #(
    .RD_LAT(RD_LAT), .BU_LAT(BU_LAT), .WR_LAT(WR_LAT),
    .ITE_LEN(ITE_LEN), .MAX_PEND(4)
  ) dut_small (
    .clk(clk), .rst(rst),
    .AGU_enable(agu), .r_enable(r_en), .ntt_enable(n_en), .w_enable(w_en), .flush(flush),
    .BN_MA_out_en(s_bn), .r_enable_out(s_r_out), .ntt_done(s_n_done), .w_enable_out(s_w_out),
    .AGU_done(s_agu_done), .ite_done(s_ite_done), .pend_cnt(s_pend), .err_ovf(s_ovf),
    .err_unf(s_unf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic drive(input logic a, input logic r, input logic n, input logic w, input logic f);
    agu = a; r_en = r; n_en = n; w_en = w; flush = f;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at the start of cycle 0 with reset released.
  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_bn"},       bn,       1'b0);
    check({tag, "_r_out"},    r_out,    1'b0);
    check({tag, "_ntt_done"}, n_done,   1'b0);
    check({tag, "_w_out"},    w_out,    1'b0);
    check({tag, "_agu_done"}, agu_done, 1'b0);
    check({tag, "_ite_done"}, ite_done, 1'b0);
    check({tag, "_pend"},     pend,     8'd0);
    check({tag, "_ovf"},      ovf,      1'b0);
    check({tag, "_unf"},      unf,      1'b0);
    check({tag, "_s_pend"},   s_pend,   8'd0);
  endtask

  // ---------------------------------------------------------------------
  // Vector table: one row per cycle, inputs of that cycle plus the outputs
  // expected to be visible during it.
  // ---------------------------------------------------------------------
  typedef struct {
    logic       agu, r, n, w;
    logic       bn, r_out, w_out;
    logic [7:0] pend;
    logic       unf;
  } vec_t;

  vec_t tbl [9];

  // ---------------------------------------------------------------------
  // Reference model for the random run. Each delay line is described by
  // the request history: a response appears L cycles after its request
  // unless a flush happened at or after that request.
  // ---------------------------------------------------------------------
  typedef enum int {P_IDLE, P_RUN, P_DRAIN, P_DONE} phase_t;

  bit     hist [3][N_RAND];
  int     lat  [3];
  int     last_flush;
  phase_t phase;
  int     grants;
  int     e_pend;
  bit     e_bn, e_ad, e_ite, e_r, e_n, e_w, e_ovf, e_unf;

  function automatic bit line_out(input int line, input int c);
    int k;
    k = c - lat[line];
    return (k >= 0) && hist[line][k] && (last_flush < k);
  endfunction

  function automatic bit line_busy(input int line, input int c);
    for (int k = c - lat[line]; k < c; k++) begin
      if (k >= 0 && hist[line][k] && last_flush < k) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Advance the model across the edge that ends cycle t.
  task automatic model_edge(input int t, input bit a, input bit r, input bit n, input bit w, input bit f);
    bit busy;
    bit nxt_bn, nxt_ad;
    busy   = line_busy(0, t) || line_busy(1, t) || line_busy(2, t);
    nxt_bn = 1'b0;
    nxt_ad = 1'b0;
    if (f) begin
      phase      = P_IDLE;
      grants     = 0;
      e_pend     = 0;
      last_flush = t;
    end else begin
      case (phase)
        P_IDLE: if (a) begin phase = P_RUN; grants = 1; nxt_bn = 1'b1; end
        P_RUN: if (a) begin
          nxt_bn = 1'b1;
          grants = grants + 1;
          if (grants == ITE_LEN) begin grants = 0; nxt_ad = 1'b1; phase = P_DRAIN; end
        end
        P_DRAIN: if (!busy && e_pend == 0 && !r && !n && !w) phase = P_DONE;
        default: phase = P_IDLE;
      endcase
      if (e_n && !w) begin
        if (e_pend == MAX_PEND) e_ovf = 1'b1;
        else                    e_pend = e_pend + 1;
      end else if (w && !e_n) begin
        if (e_pend == 0) e_unf = 1'b1;
        else             e_pend = e_pend - 1;
      end
    end
    e_bn  = nxt_bn;
    e_ad  = nxt_ad;
    e_ite = (phase == P_DONE);
    e_r   = line_out(0, t + 1);
    e_n   = line_out(1, t + 1);
    e_w   = line_out(2, t + 1);
  endtask

  // Scratch counters for the hand-written sequences.
  int bn_cnt, ad_cnt, ad_cyc, nd_cnt, nd_first, nd_last, max_pend, ite_cnt, ite_cyc, pulses;

  initial begin
    lat[0] = RD_LAT;
    lat[1] = BU_LAT;
    lat[2] = WR_LAT;

    // ---- Reset asserted before any clock edge ---------------------------
    #1 rst = 1'b0;
    #2;
    check_quiet("reset_async");

    // ---- Table: read latency, grant echo, underflow ---------------------
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      check($sformatf("tbl%0d_bn", i),    bn,    tbl[i].bn);
      check($sformatf("tbl%0d_r_out", i), r_out, tbl[i].r_out);
      check($sformatf("tbl%0d_w_out", i), w_out, tbl[i].w_out);
      check($sformatf("tbl%0d_pend", i),  pend,  tbl[i].pend);
      check($sformatf("tbl%0d_unf", i),   unf,   tbl[i].unf);
      drive(tbl[i].agu, tbl[i].r, tbl[i].n, tbl[i].w, 1'b0);
      step();
    end

    // ---- Full iteration: 64 grants, 8 results, 8 writes, drain ----------
    do_reset();
    bn_cnt = 0; ad_cnt = 0; ad_cyc = -1; nd_cnt = 0; nd_first = -1; nd_last = -1;
    max_pend = 0; ite_cnt = 0; ite_cyc = -1;
    for (int c = 0; c < 100; c++) begin
      if (bn) bn_cnt++;
      if (agu_done) begin ad_cnt++; ad_cyc = c; end
      if (n_done) begin
        nd_cnt++;
        if (nd_first < 0) nd_first = c;
        nd_last = c;
      end
      if (int'(pend) > max_pend) max_pend = int'(pend);
      if (ite_done) begin ite_cnt++; ite_cyc = c; end
      if (c == 79) check("iter_pend_drained", pend, 8'd0);
      // Grants continue past the 64th; those in DRAIN must be ignored.
      drive(c < 70, 1'b0, c < 8, (c >= 70 && c < 78), 1'b0);
      step();
    end
    check("iter_bn_count",      bn_cnt,   64);
    check("iter_agu_done_cnt",  ad_cnt,   1);
    check("iter_agu_done_cyc",  ad_cyc,   64);
    check("iter_ntt_done_cnt",  nd_cnt,   8);
    check("iter_ntt_first",     nd_first, 10);
    check("iter_ntt_last",      nd_last,  17);
    check("iter_pend_max",      max_pend, 8);
    check("iter_ite_done_cnt",  ite_cnt,  1);
    check("iter_ite_done_cyc",  ite_cyc,  80);

    // ---- Overflow (MAX_PEND=4 instance) and underflow -------------------
    do_reset();
    for (int c = 0; c < 30; c++) begin
      if (c == 20) begin
        check("ovf_small_pend", s_pend, 8'd4);
        check("ovf_small_flag", s_ovf,  1'b1);
        check("ovf_main_pend",  pend,   8'd5);
        check("ovf_main_flag",  ovf,    1'b0);
      end
      if (c == 27) begin
        check("unf_small_pend",  s_pend, 8'd0);
        check("unf_small_flag",  s_unf,  1'b1);
        check("unf_small_ovf",   s_ovf,  1'b1);
        check("unf_main_pend",   pend,   8'd0);
        check("unf_main_flag",   unf,    1'b0);
      end
      drive(1'b0, 1'b0, c < 5, (c >= 20 && c < 25), 1'b0);
      step();
    end

    // ---- Flush during RUN with results in the butterfly pipeline --------
    do_reset();
    nd_cnt = 0; ad_cnt = 0; ad_cyc = -1;
    for (int c = 0; c < 100; c++) begin
      if (c == 14) check("flush_pend_before", pend, 8'd2);
      if (c == 15) begin
        check("flush_pend_after", pend,  8'd0);
        check("flush_unf_kept",   unf,   1'b1);
        check("flush_bn_cleared", bn,    1'b0);
        check("flush_r_cleared",  r_out, 1'b0);
      end
      if (c >= 15 && c < 40 && n_done) nd_cnt++;
      if (c >= 15 && agu_done) begin ad_cnt++; ad_cyc = c; end
      drive(c < 4 || c == 14 || (c >= 20 && c < 84), c == 13,
            (c >= 2 && c < 4) || (c >= 5 && c < 8), c == 1, c == 14);
      step();
    end
    check("flush_no_ntt_done", nd_cnt, 0);
    check("flush_agu_done_cnt", ad_cnt, 1);
    check("flush_agu_done_cyc", ad_cyc, 84);

    // ---- Reset asserted mid-DRAIN ---------------------------------------
    do_reset();
    for (int c = 0; c < 69; c++) begin
      drive(c < 64, c == 63, (c >= 58 && c < 63), c == 0, 1'b0);
      step();
    end
    check("rstmid_ntt_before",  n_done, 1'b1);
    check("rstmid_pend_before", pend,   8'd1);
    check("rstmid_unf_before",  unf,    1'b1);
    #2 rst = 1'b0;
    #1;
    check_quiet("rstmid_async");
    step();
    rst = 1'b1;
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      if (bn || r_out || n_done || w_out || agu_done || ite_done || pend != 8'd0) pulses++;
      step();
    end
    check("rstmid_no_pulses", pulses, 0);

    // ---- Randomized run against the reference model ---------------------
    do_reset();
    last_flush = -1;
    phase  = P_IDLE;
    grants = 0;
    e_pend = 0;
    e_bn = 0; e_ad = 0; e_ite = 0; e_r = 0; e_n = 0; e_w = 0; e_ovf = 0; e_unf = 0;
    for (int t = 0; t < N_RAND; t++) begin
      bit a, r, n, w, f;
      check("rnd_bn",       bn,       e_bn);
      check("rnd_r_out",    r_out,    e_r);
      check("rnd_ntt_done", n_done,   e_n);
      check("rnd_w_out",    w_out,    e_w);
      check("rnd_agu_done", agu_done, e_ad);
      check("rnd_ite_done", ite_done, e_ite);
      check("rnd_pend",     pend,     8'(e_pend));
      check("rnd_ovf",      ovf,      e_ovf);
      check("rnd_unf",      unf,      e_unf);
      a = ($urandom_range(0, 9) < 7);
      r = ($urandom_range(0, 9) < 2);
      n = ($urandom_range(0, 9) < 1);
      w = ($urandom_range(0, 9) < 2);
      f = ($urandom_range(0, 199) == 0);
      drive(a, r, n, w, f);
      hist[0][t] = r;
      hist[1][t] = n;
      hist[2][t] = w;
      model_edge(t, a, r, n, w, f);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
